// File: rtl/uart_rx_fifo.sv
// First-word fall-through byte FIFO behind a UART receiver, with sticky overflow flag.
// Optional idle-timeout flag is built only when UART_RX_FIFO_TIMEOUT_EN is defined.
module uart_rx_fifo #(
    parameter int DEPTH_LOG2    = 4,
    parameter int TIMEOUT_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               in_data,
    input  logic                     in_stb,
    output logic [7:0]               out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DEPTH_LOG2:0]      level,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow,
    input  logic                     ovf_clr,
    input  logic [TIMEOUT_WIDTH-1:0] timeout_val,
    output logic                     timeout
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2:0]   LVL_ZERO = {(DEPTH_LOG2+1){1'b0}};
    localparam logic [DEPTH_LOG2:0]   LVL_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2:0]   LVL_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [7:0]            mem_r [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_r;
    logic [DEPTH_LOG2-1:0] rd_ptr_r;
    logic [DEPTH_LOG2-1:0] rd_ptr_nx_s;
    logic [DEPTH_LOG2:0]   level_r;
    logic [DEPTH_LOG2:0]   level_nx_s;
    logic                  empty_r;
    logic                  full_r;
    logic                  valid_r;
    logic                  overflow_r;
    logic [7:0]            out_data_r;
    logic [7:0]            head_nx_s;
    logic                  pop_s;
    logic                  push_s;
    logic                  drop_s;

    // Handshake decode, next occupancy and next head byte.
    // The head register is reloaded from RAM on a pop, or straight from in_data when the
    // incoming byte becomes the new head, so out_data never changes without a pop.
    always_comb begin
        pop_s       = valid_r & out_ready;
        push_s      = in_stb & (~full_r | pop_s);
        drop_s      = in_stb & full_r & ~pop_s;
        rd_ptr_nx_s = rd_ptr_r + PTR_ONE;
        case ({push_s, pop_s})
            2'b10:   level_nx_s = level_r + LVL_ONE;
            2'b01:   level_nx_s = level_r - LVL_ONE;
            default: level_nx_s = level_r;
        endcase
        if (pop_s) begin
            if (level_r > LVL_ONE) begin
                head_nx_s = mem_r[rd_ptr_nx_s];
            end else if (push_s) begin
                head_nx_s = in_data;
            end else begin
                head_nx_s = out_data_r;
            end
        end else if (push_s && (level_r == LVL_ZERO)) begin
            head_nx_s = in_data;
        end else begin
            head_nx_s = out_data_r;
        end
    end

    // Byte storage; deliberately not reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= in_data;
        end
    end

    // Pointers, occupancy, registered flags and head byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r   <= {DEPTH_LOG2{1'b0}};
            rd_ptr_r   <= {DEPTH_LOG2{1'b0}};
            level_r    <= LVL_ZERO;
            empty_r    <= 1'b1;
            full_r     <= 1'b0;
            valid_r    <= 1'b0;
            overflow_r <= 1'b0;
            out_data_r <= 8'h00;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_nx_s;
            end
            level_r    <= level_nx_s;
            empty_r    <= (level_nx_s == LVL_ZERO);
            full_r     <= (level_nx_s == LVL_FULL);
            valid_r    <= (level_nx_s != LVL_ZERO);
            out_data_r <= head_nx_s;
            // A drop in the same cycle as a clear keeps the flag set.
            if (drop_s) begin
                overflow_r <= 1'b1;
            end else if (ovf_clr) begin
                overflow_r <= 1'b0;
            end
        end
    end

    assign out_data  = out_data_r;
    assign out_valid = valid_r;
    assign level     = level_r;
    assign full      = full_r;
    assign empty     = empty_r;
    assign overflow  = overflow_r;

`ifdef UART_RX_FIFO_TIMEOUT_EN
    localparam logic [TIMEOUT_WIDTH-1:0] TMO_ZERO = {TIMEOUT_WIDTH{1'b0}};
    localparam logic [TIMEOUT_WIDTH-1:0] TMO_ONE  = {{(TIMEOUT_WIDTH-1){1'b0}}, 1'b1};

    logic [TIMEOUT_WIDTH-1:0] tmo_cnt_r;
    logic [TIMEOUT_WIDTH-1:0] tmo_cnt_nx_s;
    logic                     act_s;
    logic                     timeout_r;

    // Idle counter: reload on any activity or while empty, else count down to zero.
    always_comb begin
        act_s = push_s | pop_s;
        if (act_s || empty_r) begin
            tmo_cnt_nx_s = timeout_val;
        end else if (tmo_cnt_r != TMO_ZERO) begin
            tmo_cnt_nx_s = tmo_cnt_r - TMO_ONE;
        end else begin
            tmo_cnt_nx_s = tmo_cnt_r;
        end
    end

    // Counter and registered timeout flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt_r <= TMO_ZERO;
            timeout_r <= 1'b0;
        end else begin
            tmo_cnt_r <= tmo_cnt_nx_s;
            timeout_r <= (tmo_cnt_nx_s == TMO_ZERO) && (level_nx_s != LVL_ZERO) && !act_s;
        end
    end

    assign timeout = timeout_r;
`else
    logic unused_timeout_val_s;

    assign unused_timeout_val_s = ^timeout_val;
    assign timeout              = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: expected bytes queued on accepted pushes, compared on pops.
module tb_uart_rx_fifo;

    localparam int DL2   = 4;
    localparam int DEPTH = 16;
    localparam int TW    = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    in_data;
    logic          in_stb;
    logic [7:0]    out_data;
    logic          out_valid;
    logic          out_ready;
    logic [DL2:0]  level;
    logic          full;
    logic          empty;
    logic          overflow;
    logic          ovf_clr;
    logic [TW-1:0] timeout_val;
    logic          timeout;

    int         errors = 0;
    int         checks = 0;
    logic [7:0] exp_q[$];
    logic       m_ovf = 1'b0;
    int         m_cnt = 0;
    logic       m_tmo = 1'b0;

    uart_rx_fifo #(.DEPTH_LOG2(DL2), .TIMEOUT_WIDTH(TW)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_stb(in_stb),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .level(level), .full(full), .empty(empty), .overflow(overflow),
        .ovf_clr(ovf_clr), .timeout_val(timeout_val), .timeout(timeout)
    );

    always #5 clk = ~clk;

    // Drive one cycle and advance the reference model; outputs are then sampled 1ns after the edge.
    task automatic drive(input logic stb, input logic [7:0] d, input logic rdy, input logic clr);
        logic pop, push, pre_empty;
        in_stb = stb; in_data = d; out_ready = rdy; ovf_clr = clr;
        pre_empty = (exp_q.size() == 0);
        pop  = rdy && !pre_empty;
        push = stb && ((exp_q.size() < DEPTH) || pop);
        if (stb && !push) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        if (pop) void'(exp_q.pop_front());
        if (push) exp_q.push_back(d);
`ifdef UART_RX_FIFO_TIMEOUT_EN
        if (push || pop || pre_empty) m_cnt = int'(timeout_val);
        else if (m_cnt > 0) m_cnt = m_cnt - 1;
        m_tmo = (m_cnt == 0) && (exp_q.size() != 0) && !(push || pop);
`else
        m_tmo = 1'b0;
`endif
        @(posedge clk); #1;
        in_stb = 1'b0; out_ready = 1'b0; ovf_clr = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (level !== 5'd0 || empty !== 1'b1 || full !== 1'b0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_flags: level=%0d empty=%b full=%b valid=%b need 0/1/0/0", level, empty, full, out_valid);
        end
        checks++;
        if (overflow !== 1'b0 || timeout !== 1'b0 || out_data !== 8'h00) begin
            errors++; $display("FAIL reset_misc: ovf=%b tmo=%b data=%h need 0/0/00", overflow, timeout, out_data);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (empty !== 1'b1 || level !== 5'd0) begin
            errors++; $display("FAIL reset_release: empty=%b level=%0d need 1/0", empty, level);
        end
    endtask

    task automatic test_single();
        drive(1'b1, 8'hA5, 1'b0, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_data !== exp_q[0] || level !== 5'd1) begin
            errors++; $display("FAIL single_push: valid=%b data=%h level=%0d need 1/%h/1", out_valid, out_data, level, exp_q[0]);
        end
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        checks++;
        if (empty !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL single_pop: empty=%b valid=%b need 1/0", empty, out_valid);
        end
    endtask

    task automatic test_empty_pop();
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        checks++;
        if (level !== 5'd0 || empty !== 1'b1 || overflow !== 1'b0) begin
            errors++; $display("FAIL empty_pop: level=%0d empty=%b ovf=%b need 0/1/0", level, empty, overflow);
        end
    endtask

    task automatic test_fill_overflow();
        for (int i = 0; i < DEPTH; i++) drive(1'b1, 8'(i), 1'b0, 1'b0);
        checks++;
        if (full !== 1'b1 || level !== 5'd16 || overflow !== 1'b0) begin
            errors++; $display("FAIL fill: full=%b level=%0d ovf=%b need 1/16/0", full, level, overflow);
        end
        drive(1'b1, 8'h55, 1'b0, 1'b0);
        checks++;
        if (overflow !== 1'b1 || level !== 5'd16) begin
            errors++; $display("FAIL drop: ovf=%b level=%0d need 1/16", overflow, level);
        end
        for (int i = 0; i < DEPTH; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp_q[0]) begin
                errors++; $display("FAIL drain_order[%0d]: valid=%b data=%h need 1/%h", i, out_valid, out_data, exp_q[0]);
            end
            drive(1'b0, 8'h00, 1'b1, 1'b0);
        end
        checks++;
        if (empty !== 1'b1 || overflow !== 1'b1) begin
            errors++; $display("FAIL drained: empty=%b ovf=%b need 1/1", empty, overflow);
        end
    endtask

    task automatic test_ovf_clr();
        for (int i = 0; i < DEPTH; i++) drive(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
        drive(1'b1, 8'h99, 1'b0, 1'b1);
        checks++;
        if (overflow !== 1'b1 || overflow !== m_ovf) begin
            errors++; $display("FAIL clr_with_drop: ovf=%b need 1", overflow);
        end
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        checks++;
        if (overflow !== 1'b0 || level !== 5'd16) begin
            errors++; $display("FAIL clr_alone: ovf=%b level=%0d need 0/16", overflow, level);
        end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] last;
        checks++;
        if (out_data !== exp_q[0]) begin
            errors++; $display("FAIL fpp_head: data=%h need %h", out_data, exp_q[0]);
        end
        drive(1'b1, 8'h77, 1'b1, 1'b0);
        checks++;
        if (level !== 5'd16 || full !== 1'b1 || overflow !== 1'b0) begin
            errors++; $display("FAIL fpp_level: level=%0d full=%b ovf=%b need 16/1/0", level, full, overflow);
        end
        last = 8'h00;
        for (int i = 0; i < DEPTH; i++) begin
            checks++;
            if (out_data !== exp_q[0]) begin
                errors++; $display("FAIL fpp_drain[%0d]: data=%h need %h", i, out_data, exp_q[0]);
            end
            last = out_data;
            drive(1'b0, 8'h00, 1'b1, 1'b0);
        end
        checks++;
        if (last !== 8'h77 || empty !== 1'b1) begin
            errors++; $display("FAIL fpp_last: last=%h empty=%b need 77/1", last, empty);
        end
    endtask

    task automatic test_back_to_back();
        logic stb, rdy, clr;
        for (int c = 0; c < 400; c++) begin
            stb = (c < 200) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            rdy = (c < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 15) == 0);
            if (rdy && exp_q.size() > 0) begin
                checks++;
                if (out_data !== exp_q[0]) begin
                    errors++; $display("FAIL b2b_data c=%0d: data=%h need %h", c, out_data, exp_q[0]);
                end
            end
            drive(stb, 8'($urandom), rdy, clr);
            checks++;
            if (level !== 5'(exp_q.size()) || {full, empty, out_valid} !== {exp_q.size() == DEPTH, exp_q.size() == 0, exp_q.size() != 0}) begin
                errors++; $display("FAIL b2b_level c=%0d: level=%0d f/e/v=%b%b%b need %0d", c, level, full, empty, out_valid, exp_q.size());
            end
            checks++;
            if (overflow !== m_ovf || timeout !== m_tmo) begin
                errors++; $display("FAIL b2b_flags c=%0d: ovf=%b tmo=%b need %b/%b", c, overflow, timeout, m_ovf, m_tmo);
            end
        end
    endtask

    task automatic test_timeout();
        int first;
        while (exp_q.size() > 0) drive(1'b0, 8'h00, 1'b1, 1'b0);
        timeout_val = 16'd10;
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        drive(1'b1, 8'h42, 1'b0, 1'b0);
        first = -1;
        for (int i = 1; i <= 20; i++) begin
            drive(1'b0, 8'h00, 1'b0, 1'b0);
            checks++;
            if (timeout !== m_tmo) begin
                errors++; $display("FAIL tmo_idle[%0d]: tmo=%b need %b", i, timeout, m_tmo);
            end
            if (timeout === 1'b1 && first < 0) first = i;
        end
`ifdef UART_RX_FIFO_TIMEOUT_EN
        checks++;
        if (first != 10) begin
            errors++; $display("FAIL tmo_expiry: first idle cycle with timeout=%0d need 10", first);
        end
`endif
        checks++;
        if (out_data !== exp_q[0]) begin
            errors++; $display("FAIL tmo_data: data=%h need %h", out_data, exp_q[0]);
        end
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        checks++;
        if (timeout !== 1'b0 || empty !== 1'b1) begin
            errors++; $display("FAIL tmo_clear: tmo=%b empty=%b need 0/1", timeout, empty);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < DEPTH + 1; i++) drive(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
        for (int i = 0; i < 11; i++) drive(1'b0, 8'h00, 1'b1, 1'b0);
        checks++;
        if (level !== 5'd5 || overflow !== 1'b1) begin
            errors++; $display("FAIL pre_reset: level=%0d ovf=%b need 5/1", level, overflow);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (level !== 5'd0 || out_valid !== 1'b0 || overflow !== 1'b0 || empty !== 1'b1) begin
            errors++; $display("FAIL mid_reset: level=%0d valid=%b ovf=%b empty=%b need 0/0/0/1", level, out_valid, overflow, empty);
        end
        exp_q.delete(); m_ovf = 1'b0; m_cnt = 0; m_tmo = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        drive(1'b1, 8'h3C, 1'b0, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h3C || level !== 5'd1) begin
            errors++; $display("FAIL post_reset: valid=%b data=%h level=%0d need 1/3c/1", out_valid, out_data, level);
        end
    endtask

    initial begin
        rst = 1'b1; in_data = 8'h00; in_stb = 1'b0; out_ready = 1'b0;
        ovf_clr = 1'b0; timeout_val = 16'd10;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_empty_pop();
        test_fill_overflow();
        test_ovf_clr();
        test_full_push_pop();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 The block SHALL have parameter DEPTH_LOG2, default 4, which sets FIFO depth to 2^DEPTH_LOG2 bytes (legal 2..8).
REQ-002 The block SHALL have parameter TIMEOUT_WIDTH, default 16, the width of the idle-timeout counter.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port in_data, input, 8 bits: received byte, from the UART receiver data output.
REQ-006 The block SHALL have port in_stb, input, 1 bit: one-cycle strobe marking in_data valid, from the UART receiver stb output.
REQ-007 The block SHALL have port out_data, output, 8 bits: head-of-FIFO byte.
REQ-008 The block SHALL have port out_valid, output, 1 bit: out_data holds a valid byte.
REQ-009 The block SHALL have port out_ready, input, 1 bit: consumer pop request.
REQ-010 The block SHALL have port level, output, DEPTH_LOG2+1 bits: current occupancy.
REQ-011 The block SHALL have ports full and empty, outputs, 1 bit each: occupancy flags.
REQ-012 The block SHALL have port overflow, output, 1 bit: sticky dropped-byte flag.
REQ-013 The block SHALL have port ovf_clr, input, 1 bit: overflow clear pulse.
REQ-014 The block SHALL have port timeout_val, input, TIMEOUT_WIDTH bits: idle-timeout reload value (used only with the timeout feature).
REQ-015 The block SHALL have port timeout, output, 1 bit: idle-timeout flag.

Function
REQ-016 Pop SHALL occur when out_valid & out_ready; push SHALL occur when in_stb & (~full | pop).
REQ-017 A pushed byte SHALL be visible (out_valid=1, out_data) on the cycle after in_stb when the FIFO was empty (first-word fall-through, 1-cycle latency).
REQ-018 level SHALL update on the cycle after a push or pop: +1 push only, -1 pop only, unchanged for both or neither.
REQ-019 empty SHALL equal (level==0), full SHALL equal (level==2^DEPTH_LOG2), and out_valid SHALL equal ~empty.
REQ-020 Read/write pointers SHALL be DEPTH_LOG2 bits and wrap modulo depth without stall.
REQ-021 When full, a push coinciding with a pop SHALL be accepted and level SHALL stay at full.
REQ-022 in_stb while full without pop SHALL drop the byte, leave FIFO contents unchanged, and set overflow on the next cycle.
REQ-023 overflow SHALL stay set until an ovf_clr cycle; a drop in the same cycle as ovf_clr SHALL win (overflow stays 1).
REQ-024 out_ready while empty SHALL have no effect.
REQ-025 out_data SHALL be undefined-but-stable while out_valid=0 and SHALL NOT change while out_valid=1 and no pop.

Reset
REQ-026 Asserting rst SHALL immediately clear pointers, level=0, empty=1, full=0, out_valid=0, overflow=0, timeout=0, and the timeout counter to 0, discarding any buffered bytes, including mid-transfer.
REQ-027 out_data reset value SHALL be 8'h00; RAM contents SHALL NOT be reset.

Configuration
REQ-028 The timeout feature SHALL be controlled by macro UART_RX_FIFO_TIMEOUT_EN.
REQ-029 With UART_RX_FIFO_TIMEOUT_EN defined, the counter SHALL reload with timeout_val on any push, any pop, or while empty, and otherwise SHALL decrement, saturating at 0.
REQ-030 With the macro defined, timeout SHALL be 1 while the counter is 0, the FIFO is non-empty, and no push or pop occurred in the previous cycle; it SHALL clear on the cycle after the next push, pop or empty.
REQ-031 Without the macro, timeout SHALL be tied to 0, timeout_val SHALL be ignored, and no counter logic SHALL be synthesized.

Verification
REQ-032 Reset, then push 8'hA5 -> next cycle out_valid=1, out_data=8'hA5, level=1; pop -> empty=1 next cycle.
REQ-033 Push 0x00..0x0F (depth 16), no pops -> full=1, level=16; push 0x55 -> overflow=1 and 16 pops return 0x00..0x0F in order.
REQ-034 Full FIFO, simultaneous in_stb=0x77 and pop -> level stays 16, overflow=0, 0x77 emerges last.
REQ-035 overflow=1, ovf_clr together with a dropped push -> overflow remains 1; ovf_clr alone -> overflow=0 next cycle.
REQ-036 Macro defined, timeout_val=10, push one byte then idle -> timeout=1 after counter expiry (about 11 cycles); pop -> timeout=0 next cycle.
REQ-037 Assert rst while level=5 -> level=0, out_valid=0, overflow=0 immediately; a subsequent push of 0x3C is read back as 0x3C.
